// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array edge feeder and its drain controller:
// FSM encoding, lane slicing and the fixed array drain latency.
package systolic_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Cycles from the last accepted beat until PE(N-1,N-1) holds its final result.
    function automatic int drain_latency(input int n);
        return 2 * n;
    endfunction

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register for one feeder lane; output is the input DEPTH cycles earlier.
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = din;
        for (int k = 1; k < DEPTH; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_edge_feeder.sv
// Skews A columns / B rows onto the west and north array edges, zero-filling bubbles,
// then flushes zeros until the far-corner PE is final and pulses done.
module systolic_edge_feeder
    import systolic_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int K_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K_WIDTH-1:0]      k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] a_col,
    input  logic [N*DATA_WIDTH-1:0] b_row,
    output logic [N*DATA_WIDTH-1:0] west_out,
    output logic [N*DATA_WIDTH-1:0] north_out,
    output logic                    busy,
    output logic                    done
);

    localparam int DRAIN  = drain_latency(N);
    localparam int FLUSHW = $clog2(DRAIN) + 1;
    localparam int CNT_W  = (K_WIDTH > FLUSHW) ? K_WIDTH : FLUSHW;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    hs;
    logic [N*DATA_WIDTH-1:0] west_in, north_in;

    // Outputs decode the state register only, so in_ready never depends on in_valid.
    assign in_ready = (state_q == ST_STREAM);
    assign busy     = (state_q == ST_STREAM) || (state_q == ST_FLUSH);
    assign done     = (state_q == ST_DONE);
    assign hs       = in_valid & in_ready;

    // Every non-handshake cycle feeds a zero bubble into all lanes alike.
    assign west_in  = hs ? a_col : '0;
    assign north_in = hs ? b_row : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STREAM;
                        cnt_d   = CNT_W'(k_len);
                    end
                end
            end
            ST_STREAM: begin
                if (hs) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_W'(DRAIN - 1);
                    end
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane i is i+1 deep on both edges so operands meet on the array diagonal.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .DEPTH      (i + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_west (
            .clk  (clk),
            .rst  (rst),
            .din  (west_in[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .dout (west_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
        );

        skew_delay_line #(
            .DEPTH      (i + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_north (
            .clk  (clk),
            .rst  (rst),
            .din  (north_in[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .dout (north_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Scoreboard bench: a posedge sampler records accepted beats and models an N x N PE array
// on the feeder edges; a negedge monitor compares edges, handshake flags, done and results.
module tb_systolic_edge_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 8;
    localparam int VW = N * DW;

    typedef logic [N*N-1:0][31:0] mat_t;

    logic          clk = 0;
    logic          rst = 0;
    logic          start = 0;
    logic [KW-1:0] k_len = '0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [VW-1:0] a_col = '0;
    logic [VW-1:0] b_row = '0;
    logic [VW-1:0] west_out;
    logic [VW-1:0] north_out;
    logic          busy;
    logic          done;

    systolic_edge_feeder #(.N(N), .DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_col     (a_col),
        .b_row     (b_row),
        .west_out  (west_out),
        .north_out (north_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_cnt = 0;

    // Reference state: tile progress, beat history keyed by handshake cycle, expectations.
    bit            tb_stream  = 0;
    int            tb_left    = 0;
    int            tb_done_at = -1;
    logic [VW-1:0] hist_a[int];
    logic [VW-1:0] hist_b[int];
    int            done_q[$];
    mat_t          res_q[$];

    logic          pe_clr = 0;
    int            pe_acc[N][N];
    logic [DW-1:0] pe_w[N][N], pe_n[N][N];
    logic [DW-1:0] nw[N][N], nn[N][N];

    logic [VW-1:0] tile_a[$];
    logic [VW-1:0] tile_b[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Sampler: runs on the active edge, sees pre-edge DUT values.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            tb_stream  = 0;
            tb_left    = 0;
            tb_done_at = -1;
            hist_a.delete();
            hist_b.delete();
            done_q.delete();
            res_q.delete();
        end
        if (rst || pe_clr) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pe_acc[i][j] = 0;
                    pe_w[i][j]   = '0;
                    pe_n[i][j]   = '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    nw[i][j] = (j == 0) ? west_out[i*DW +: DW] : pe_w[i][j-1];
                    nn[i][j] = (i == 0) ? north_out[j*DW +: DW] : pe_n[i-1][j];
                    if (nw[i][j] != 0 && nn[i][j] != 0)
                        pe_acc[i][j] += int'(nw[i][j]) * int'(nn[i][j]);
                end
            pe_w = nw;
            pe_n = nn;
        end
        if (!rst) begin
            if (tb_stream && in_valid) begin
                hist_a[cyc] = a_col;
                hist_b[cyc] = b_row;
                tb_left--;
                if (tb_left == 0) begin
                    tb_stream  = 0;
                    tb_done_at = cyc + 2 * N;
                    done_q.push_back(tb_done_at);
                end
            end else if (start && !tb_stream && tb_done_at < cyc) begin
                if (k_len == 0) begin
                    tb_done_at = cyc + 1;
                    done_q.push_back(tb_done_at);
                end else begin
                    tb_stream = 1;
                    tb_left   = int'(k_len);
                end
            end
        end
        cyc++;
    end

    // Monitor: compares away from the active edge.
    initial forever begin
        logic [VW-1:0] exp_w, exp_n, ta, tb;
        mat_t g;
        @(negedge clk);
        if (!rst) begin
            exp_w = '0;
            exp_n = '0;
            for (int i = 0; i < N; i++) begin
                if (hist_a.exists(cyc - 1 - i)) begin
                    ta = hist_a[cyc - 1 - i];
                    tb = hist_b[cyc - 1 - i];
                    exp_w[i*DW +: DW] = ta[i*DW +: DW];
                    exp_n[i*DW +: DW] = tb[i*DW +: DW];
                end
            end
            chk("west_out", 64'(west_out), 64'(exp_w));
            chk("north_out", 64'(north_out), 64'(exp_n));
            chk("in_ready", 64'(in_ready), 64'(tb_stream));
            chk("busy", 64'(busy), 64'(tb_stream || tb_done_at > cyc));
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 64'(1), 64'(0));
                end else begin
                    chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                    if (res_q.size() == 0) begin
                        chk("result_missing", 64'(0), 64'(1));
                    end else begin
                        g = res_q.pop_front();
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++)
                                chk($sformatf("pe_%0d_%0d", i, j), 64'(pe_acc[i][j]), 64'(g[i*N+j]));
                    end
                end
            end else if (done_q.size() != 0 && done_q[0] < cyc) begin
                chk("done_missed", 64'(0), 64'(done_q.pop_front()));
            end
        end
    end

    task automatic fill_rand(input int k);
        logic [VW-1:0] va, vb;
        tile_a.delete();
        tile_b.delete();
        repeat (k) begin
            for (int i = 0; i < N; i++) begin
                va[i*DW +: DW] = DW'($urandom_range(1, 15));
                vb[i*DW +: DW] = DW'($urandom_range(1, 15));
            end
            tile_a.push_back(va);
            tile_b.push_back(vb);
        end
    endtask

    task automatic fill_const(input int k, input logic [VW-1:0] va, input logic [VW-1:0] vb);
        tile_a.delete();
        tile_b.delete();
        repeat (k) begin
            tile_a.push_back(va);
            tile_b.push_back(vb);
        end
    endtask

    // vmode: 0 = valid every cycle, 1 = 1,0,0 repeating, 2 = random.
    task automatic run_tile(input int vmode, input int abort_after, input bit start_in_stream);
        int k, idx, step, w0, s;
        bit v;
        mat_t g;
        logic [VW-1:0] va, vb;
        k = tile_a.size();
        g = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) begin
                    va = tile_a[kk];
                    vb = tile_b[kk];
                    s += int'(va[i*DW +: DW]) * int'(vb[j*DW +: DW]);
                end
                g[i*N+j] = 32'(s);
            end
        @(negedge clk);
        pe_clr = 1;
        @(negedge clk);
        pe_clr = 0;
        res_q.push_back(g);
        w0    = done_cnt;
        start = 1;
        k_len = KW'(k);
        @(negedge clk);
        start = 0;
        k_len = KW'($urandom);
        idx   = 0;
        step  = 0;
        while (idx < k) begin
            case (vmode)
                0:       v = 1;
                1:       v = (step % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            if (v) begin
                a_col = tile_a[idx];
                b_row = tile_b[idx];
                idx++;
            end else begin
                a_col = VW'($urandom);
                b_row = VW'($urandom);
            end
            if (start_in_stream && step == 1) begin
                start = 1;
                k_len = '0;
            end else begin
                start = 0;
            end
            step++;
            @(negedge clk);
        end
        in_valid = 0;
        start    = 0;
        a_col    = VW'($urandom);
        b_row    = VW'($urandom);
        if (abort_after >= 0) begin
            repeat (abort_after) @(negedge clk);
            #2 rst = 1;
            #1;
            chk("abort_west", 64'(west_out), 64'(0));
            chk("abort_north", 64'(north_out), 64'(0));
            chk("abort_ready", 64'(in_ready), 64'(0));
            chk("abort_busy", 64'(busy), 64'(0));
            chk("abort_done", 64'(done), 64'(0));
            @(negedge clk);
            rst = 0;
            repeat (3 * N) @(negedge clk);
            chk("abort_no_done", 64'(done_cnt - w0), 64'(0));
        end else begin
            for (int t = 0; t < 2 * N + 4 && done_cnt == w0; t++) @(posedge clk);
            @(negedge clk);
            if (done_cnt == w0) chk("done_timeout", 64'(0), 64'(1));
        end
    endtask

    initial begin
        #2 rst = 1;
        #1;
        chk("reset_west", 64'(west_out), 64'(0));
        chk("reset_north", 64'(north_out), 64'(0));
        chk("reset_ready", 64'(in_ready), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        rst = 0;

        fill_const(1, 32'h04030201, 32'h08070605);
        run_tile(0, -1, 0);

        fill_const(4, 32'h02020202, 32'h03030303);
        run_tile(0, -1, 0);

        fill_rand(4);
        run_tile(0, -1, 0);
        run_tile(1, -1, 0);

        tile_a.delete();
        tile_b.delete();
        run_tile(0, -1, 0);

        fill_rand(6);
        run_tile(2, -1, 1);

        fill_rand(3);
        run_tile(0, 2, 0);

        fill_rand(4);
        run_tile(0, -1, 0);

        for (int r = 0; r < 6; r++) begin
            fill_rand($urandom_range(1, 10));
            run_tile(2, -1, r[0]);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_edge_feeder.md
# systolic_edge_feeder

Skewing feeder that drives the west and north edges of the N×N systolic PE array. It accepts one A-column and one B-row per handshake. It delays lane i by i extra cycles so operands meet diagonally inside the array, and inserts zero bubbles whenever no data is available. After the last beat it flushes zeros until the far-corner PE has consumed its final operands, then pulses `done` so the controller can read results.

## Interface
- `N`, 4, array dimension (lanes per edge).
- `DATA_WIDTH`, 8, operand width per lane.
- `K_WIDTH`, 8, width of the k-step count.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `k_len`  in  K_WIDTH  number of A/B beats in the tile; sampled with `start`.
- `in_valid`  in  1  `a_col`/`b_row` beat valid.
- `in_ready`  out  1  feeder accepts a beat (high only in STREAM).
- `a_col`  in  N*DATA_WIDTH  lane i = bits [i*DW +: DW] = A[i][k].
- `b_row`  in  N*DATA_WIDTH  lane j = B[k][j].
- `west_out`  out  N*DATA_WIDTH  lane i drives `inp_west` of PE(i,0).
- `north_out`  out  N*DATA_WIDTH  lane j drives `inp_north` of PE(0,j).
- `busy`  out  1  high in STREAM and FLUSH.
- `done`  out  1  one-cycle pulse; all PE results final in that cycle.

## Operation
- FSM states: IDLE, STREAM, FLUSH, DONE.
- **IDLE:**
  - `start` with `k_len`≠0 → STREAM; load beat counter = `k_len`.
  - `start` with `k_len`=0 → DONE.
- **STREAM:**
  - `in_ready`=1.
  - Handshake (`in_valid`&`in_ready`): shift the beat into every lane and decrement the counter.
  - Last beat (counter=1) → FLUSH; load flush counter = 2N-1.
- **FLUSH:** shift zeros into all lanes and decrement each cycle; at counter=1 → DONE.
- **DONE:** `done`=1 for one cycle → IDLE.
- Any cycle with no handshake (STREAM without `in_valid`, FLUSH, IDLE) shifts zeros into all lanes. Bubbles hit every lane identically, so diagonal alignment is preserved.
- Lane i (west and north alike) is a shift register of depth i+1, so output = input accepted i+1 cycles earlier.
- Zero operands are indistinguishable from bubbles. The PE skips accumulation on zero, which is arithmetically harmless.
- `start` outside IDLE is ignored; `in_valid` outside STREAM is ignored.
- The feeder does not clear PE accumulators; that is the controller's job, done via array `rst` before `start`.
- Reset values: all lane registers 0, `west_out`/`north_out` 0, state IDLE, `in_ready`/`busy`/`done` 0, counters 0.
- Reset mid-operation: everything returns to reset values immediately; no `done` is produced for the aborted tile.

## Timing
- The beat accepted at the edge ending cycle T appears on lane i in cycle T+1+i only, and is zero otherwise (unless another beat follows).
- PE(i,j) samples that beat at the end of cycle T+1+i+j. The last corner PE(N-1,N-1) updates its result, visible in cycle T+2N.
- `done` is asserted in cycle T+2N, where T is the cycle of the last handshake:
  - FLUSH occupies cycles T+1..T+2N-1.
  - DONE occupies cycle T+2N.
- `k_len`=0: `start` in cycle S → `done` in cycle S+1.
- `in_ready` is a registered state decode with no combinational path from `in_valid`.
- Throughput: one beat per cycle, sustained.

## Structure
- Shared package/header `systolic_pkg`:
  - FSM state encoding.
  - Lane-slice helper.
  - Drain latency constant 2N (shared with the result-drain controller).
- Sub-module `skew_delay_line` (params DEPTH, DATA_WIDTH; in, out; async reset to 0). Instantiate 2N times with DEPTH=i+1.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs 0 asynchronously, `in_ready`=0, state IDLE.
- Single beat, N=4, `k_len`=1:
  - Stimulus: `a_col` lanes {1,2,3,4}, `b_row` {5,6,7,8}.
  - West lane i = a_i only in cycle T+1+i, north similarly.
  - `done` in T+8.
- Full 4×4 tile:
  - Feeder plus 4×4 PE array, `k_len`=4, A all 2, B all 3 → every PE result = 24 when `done` fires.
  - Repeat with random nonzero INT4 values vs golden matmul.
- Bubbles: same random tile with `in_valid` toggled 1,0,0,1,… → identical results; `done` exactly 2N cycles after the last handshake.
- `k_len`=0: `start` in cycle S → `done` in S+1, edges stay 0, `busy` never high.
- Abort and protocol checks:
  - `rst` during FLUSH → no `done`, outputs 0.
  - Next tile after reset completes correctly.
  - `start` pulsed during STREAM is ignored.
